// File: rtl/ifft_butterfly_pipe_pkg.sv
// Shared types, widths and saturation helpers for the inverse-FFT butterfly.
package ifft_pkg;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned TW_W    = 12;
  localparam int unsigned TW_FRAC = 10;

  localparam int unsigned PROD_W = DATA_W + TW_W;  // one twiddle*data product
  localparam int unsigned SUM_W  = PROD_W + 1;     // sum of two products
  localparam int unsigned P_W    = DATA_W + 1;     // scaled conj(W)*B half
  localparam int unsigned S_W    = DATA_W + 2;     // A +/- P before halving

  localparam int P_MAX = (1 << (P_W - 1)) - 1;
  localparam int P_MIN = -(1 << (P_W - 1));
  localparam int D_MAX = (1 << (DATA_W - 1)) - 1;
  localparam int D_MIN = -(1 << (DATA_W - 1));

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic                  clip;
    logic signed [P_W-1:0] val;
  } sat13_t;

  typedef struct packed {
    logic                     clip;
    logic signed [DATA_W-1:0] val;
  } sat12_t;

  // Clamp a shifted product sum into the 13-bit intermediate range.
  function automatic sat13_t sat13(input logic signed [SUM_W-1:0] x);
    sat13_t r;
    r.clip = 1'b1;
    if (x > SUM_W'(P_MAX))      r.val = P_W'(P_MAX);
    else if (x < SUM_W'(P_MIN)) r.val = P_W'(P_MIN);
    else begin
      r.val  = x[P_W-1:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

  // Clamp a halved butterfly result into the 12-bit output range.
  function automatic sat12_t sat12(input logic signed [S_W-1:0] x);
    sat12_t r;
    r.clip = 1'b1;
    if (x > S_W'(D_MAX))      r.val = DATA_W'(D_MAX);
    else if (x < S_W'(D_MIN)) r.val = DATA_W'(D_MIN);
    else begin
      r.val  = x[DATA_W-1:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ifft_butterfly_pipe_if.sv
// Valid/ready stream bundle carrying butterfly operands in and results out.
interface ifft_butterfly_pipe_if;
  import ifft_pkg::*;

  logic  in_valid;
  logic  in_ready;
  cplx_t in_a;
  cplx_t in_b;
  cplx_t in_w;
  logic  out_valid;
  logic  out_ready;
  cplx_t out_y0;
  cplx_t out_y1;

  modport master (
    output in_valid, in_a, in_b, in_w, out_ready,
    input  in_ready, out_valid, out_y0, out_y1
  );

  modport slave (
    input  in_valid, in_a, in_b, in_w, out_ready,
    output in_ready, out_valid, out_y0, out_y1
  );

endinterface

// File: rtl/ifft_butterfly_pipe_cmul_conj.sv
// conj(W)*B: registered products (stage 1), then scale and saturate (stage 2).
// IFFT_BF_ROUND_EN adds a half-LSB before the Q1.10 scaling shift.
module cmul_conj
  import ifft_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  adv,
  input  cplx_t                 b,
  input  cplx_t                 w,
  output logic signed [P_W-1:0] p_re,
  output logic signed [P_W-1:0] p_im,
  output logic                  clip_c
);

  logic signed [PROD_W-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [SUM_W-1:0]  sum_re, sum_im;
  sat13_t                   sat_re, sat_im;

  // Stage 1: the four partial products.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rr <= '0;
      m_ii <= '0;
      m_ri <= '0;
      m_ir <= '0;
    end else if (adv) begin
      m_rr <= PROD_W'(w.re) * PROD_W'(b.re);
      m_ii <= PROD_W'(w.im) * PROD_W'(b.im);
      m_ri <= PROD_W'(w.re) * PROD_W'(b.im);
      m_ir <= PROD_W'(w.im) * PROD_W'(b.re);
    end
  end

  // Combine products for the conjugated twiddle, scale and saturate.
  always_comb begin
`ifdef IFFT_BF_ROUND_EN
    sum_re = SUM_W'(m_rr) + SUM_W'(m_ii) + SUM_W'(1 << (TW_FRAC - 1));
    sum_im = SUM_W'(m_ri) - SUM_W'(m_ir) + SUM_W'(1 << (TW_FRAC - 1));
`else
    sum_re = SUM_W'(m_rr) + SUM_W'(m_ii);
    sum_im = SUM_W'(m_ri) - SUM_W'(m_ir);
`endif
    sat_re = sat13(sum_re >>> TW_FRAC);
    sat_im = sat13(sum_im >>> TW_FRAC);
    clip_c = sat_re.clip | sat_im.clip;
  end

  // Stage 2: register the scaled product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_re <= '0;
      p_im <= '0;
    end else if (adv) begin
      p_re <= sat_re.val;
      p_im <= sat_im.val;
    end
  end

endmodule

// File: rtl/ifft_butterfly_pipe.sv
// Pipelined radix-2 inverse-FFT butterfly: y0/y1 = (A +/- conj(W)*B) / 2.
// Three rigid stages with a full-pipeline stall; sticky saturation flag.
// IFFT_BF_ROUND_EN selects round-half-up instead of truncation.
module ifft_butterfly_pipe
  import ifft_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  ifft_butterfly_pipe_if.slave  bus,
  output logic                  ovf_flag,
  input  logic                  ovf_clr
);

  logic                  adv_c;
  logic                  v1, v2;
  cplx_t                 a1, a2;
  logic signed [P_W-1:0] p_re, p_im;
  logic                  clip2_c, clip3_c;
  logic signed [S_W-1:0] s0_re, s0_im, s1_re, s1_im;
  sat12_t                y0_re, y0_im, y1_re, y1_im;

  // Whole pipeline moves only when the output slot is free or being taken.
  assign adv_c       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv_c;

  // Stage valids and the A delay line alongside the multiplier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      a1 <= '0;
      a2 <= '0;
    end else if (adv_c) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      a1 <= bus.in_a;
      a2 <= a1;
    end
  end

  cmul_conj u_cmul (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (adv_c),
    .b       (bus.in_b),
    .w       (bus.in_w),
    .p_re    (p_re),
    .p_im    (p_im),
    .clip_c  (clip2_c)
  );

  // Stage 3 arithmetic: add/sub, halve, saturate.
  always_comb begin
`ifdef IFFT_BF_ROUND_EN
    s0_re = S_W'(a2.re) + S_W'(p_re) + S_W'(1);
    s0_im = S_W'(a2.im) + S_W'(p_im) + S_W'(1);
    s1_re = S_W'(a2.re) - S_W'(p_re) + S_W'(1);
    s1_im = S_W'(a2.im) - S_W'(p_im) + S_W'(1);
`else
    s0_re = S_W'(a2.re) + S_W'(p_re);
    s0_im = S_W'(a2.im) + S_W'(p_im);
    s1_re = S_W'(a2.re) - S_W'(p_re);
    s1_im = S_W'(a2.im) - S_W'(p_im);
`endif
    y0_re   = sat12(s0_re >>> 1);
    y0_im   = sat12(s0_im >>> 1);
    y1_re   = sat12(s1_re >>> 1);
    y1_im   = sat12(s1_im >>> 1);
    clip3_c = y0_re.clip | y0_im.clip | y1_re.clip | y1_im.clip;
  end

  // Output register; holds while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_y0    <= '0;
      bus.out_y1    <= '0;
    end else if (adv_c) begin
      bus.out_valid <= v2;
      bus.out_y0    <= {y0_re.val, y0_im.val};
      bus.out_y1    <= {y1_re.val, y1_im.val};
    end
  end

  // Sticky overflow: a clip on an advancing valid stage beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_flag <= 1'b0;
    end else begin
      ovf_flag <= (ovf_flag && !ovf_clr)
                || (adv_c && v1 && clip2_c)
                || (adv_c && v2 && clip3_c);
    end
  end

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Self-checking bench for ifft_butterfly_pipe: directed cases plus a random
// stream scored against an integer-arithmetic model of the butterfly.
module tb_ifft_butterfly_pipe;
  import ifft_pkg::*;

`ifdef IFFT_BF_ROUND_EN
  localparam int RND_P = 512;
  localparam int RND_Y = 1;
`else
  localparam int RND_P = 0;
  localparam int RND_Y = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic ovf_flag;
  logic ovf_clr;

  ifft_butterfly_pipe_if bus();

  ifft_butterfly_pipe dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .ovf_flag (ovf_flag),
    .ovf_clr  (ovf_clr)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [48:0] exp_q[$];
  bit          any_clip;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cplx_t mk(input int re, input int im);
    return {12'(re), 12'(im)};
  endfunction

  function automatic cplx_t rnd_c(input int lim);
    int re, im;
    re = int'($urandom_range(2 * lim)) - lim;
    im = int'($urandom_range(2 * lim)) - lim;
    return mk(re, im);
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic bit clips(input int v, input int hi);
    return (v > hi) || (v < -hi - 1);
  endfunction

  // Reference: {clip, y0.re, y0.im, y1.re, y1.im} from the math definition.
  function automatic logic [48:0] model(input cplx_t a, input cplx_t b, input cplx_t w);
    int ar, ai, br, bi, wr, wi, pr, pi, y0r, y0i, y1r, y1i;
    bit c;
    ar = int'(a.re); ai = int'(a.im);
    br = int'(b.re); bi = int'(b.im);
    wr = int'(w.re); wi = int'(w.im);
    // conj(W)*B = (wr*br + wi*bi) + j(wr*bi - wi*br), in Q1.10
    pr = (wr * br + wi * bi + RND_P) >>> 10;
    pi = (wr * bi - wi * br + RND_P) >>> 10;
    c  = clips(pr, 4095) || clips(pi, 4095);
    pr = clamp(pr, 4095);
    pi = clamp(pi, 4095);
    y0r = (ar + pr + RND_Y) >>> 1;
    y0i = (ai + pi + RND_Y) >>> 1;
    y1r = (ar - pr + RND_Y) >>> 1;
    y1i = (ai - pi + RND_Y) >>> 1;
    c = c || clips(y0r, 2047) || clips(y0i, 2047) || clips(y1r, 2047) || clips(y1i, 2047);
    return {c, 12'(clamp(y0r, 2047)), 12'(clamp(y0i, 2047)),
            12'(clamp(y1r, 2047)), 12'(clamp(y1i, 2047))};
  endfunction

  // One clock: drive inputs, check handshake and output against the scoreboard.
  task automatic cycle(input bit v, input cplx_t a, input cplx_t b, input cplx_t w,
                       input bit rdy, output bit acc, output bit ov,
                       output cplx_t y0, output cplx_t y1);
    logic [48:0] m;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_w      = w;
    bus.out_ready = rdy;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !rdy)));
    ov  = bus.out_valid;
    y0  = bus.out_y0;
    y1  = bus.out_y1;
    acc = v && bus.in_ready;
    if (ov) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(ov), 32'd0);
      end else begin
        check("y0", 32'(y0), 32'(exp_q[0][47:24]));
        check("y1", 32'(y1), 32'(exp_q[0][23:0]));
        if (rdy) void'(exp_q.pop_front());
      end
    end
    if (acc) begin
      m = model(a, b, w);
      any_clip = any_clip || m[48];
      exp_q.push_back(m);
    end
    @(posedge clk);
  endtask

  // Single vector on an idle pipe: accept, latency and exact result.
  task automatic directed(input string tag, input cplx_t a, input cplx_t b, input cplx_t w,
                          input cplx_t e0, input cplx_t e1);
    bit    acc, ov;
    cplx_t y0, y1;
    int    n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      cycle(1'b1, a, b, w, 1'b1, acc, ov, y0, y1);
      n++;
    end
    check({tag, "_acc"}, 32'(acc), 32'd1);
    ov = 1'b0;
    n  = 0;
    while (!ov && n < 10) begin
      cycle(1'b0, a, b, w, 1'b1, acc, ov, y0, y1);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_y0"}, 32'(y0), 32'(e0));
    check({tag, "_y1"}, 32'(y1), 32'(e1));
  endtask

  initial begin
    bit    acc, ov;
    cplx_t y0, y1;
    int    idx, cyc;
    cplx_t va[8], vb[8], vw[8];

    any_clip      = 1'b0;
    reset_n       = 1'b0;
    ovf_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_w      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y0", 32'(bus.out_y0), 32'd0);
    check("rst_y1", 32'(bus.out_y1), 32'd0);
    check("rst_ovf", 32'(ovf_flag), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Identity and quarter-turn twiddles.
    directed("t1", mk(100, 50), mk(20, -10), mk(1024, 0), mk(60, 20), mk(40, 30));
    directed("t2", mk(100, 50), mk(20, -10), mk(0, 1024), mk(45, 15), mk(55, 35));

    // Back-to-back stream under a 1-0-0-1 downstream ready pattern.
    for (int i = 0; i < 8; i++) begin
      va[i] = rnd_c(500);
      vb[i] = rnd_c(500);
      vw[i] = rnd_c(1024);
    end
    idx = 0;
    cyc = 0;
    while (cyc < 100 && (idx < 8 || exp_q.size() != 0)) begin
      cycle(idx < 8, va[idx % 8], vb[idx % 8], vw[idx % 8],
            (cyc % 4 == 0) || (cyc % 4 == 3), acc, ov, y0, y1);
      if (acc) idx++;
      cyc++;
    end
    check("t3_sent", 32'(idx), 32'd8);
    check("t3_drain", 32'(exp_q.size()), 32'd0);
    check("t3_ovf", 32'(ovf_flag), 32'd0);

    // Saturation and sticky flag with clear.
    directed("t4", mk(0, 0), mk(-2048, -2048), mk(-2048, -2048),
             mk(2047, 0), mk((RND_Y != 0) ? -2047 : -2048, 0));
    check("t4_ovf_set", 32'(ovf_flag), 32'd1);
    repeat (3) cycle(1'b0, '0, '0, '0, 1'b1, acc, ov, y0, y1);
    check("t4_ovf_sticky", 32'(ovf_flag), 32'd1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(ovf_flag), 32'd0);

    // Rounding mode on an odd sum.
    directed("t5", mk(3, 0), mk(0, 0), mk(1024, 0),
             mk((RND_Y != 0) ? 2 : 1, 0), mk((RND_Y != 0) ? 2 : 1, 0));
    check("t5_ovf", 32'(ovf_flag), 32'd0);

    // Reset with data in flight.
    repeat (3) cycle(1'b1, rnd_c(500), rnd_c(500), rnd_c(1024), 1'b1, acc, ov, y0, y1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    #1;
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_y0", 32'(bus.out_y0), 32'd0);
    check("t6_y1", 32'(bus.out_y1), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    directed("t6", mk(100, 50), mk(20, -10), mk(1024, 0), mk(60, 20), mk(40, 30));

    // Random stream with random stalls; flag must match model clipping.
    any_clip = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0,
            rnd_c(2048), rnd_c(2048), ((i % 2) != 0) ? rnd_c(2048) : rnd_c(1024),
            ($urandom % 3) != 0, acc, ov, y0, y1);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      cycle(1'b0, '0, '0, '0, 1'b1, acc, ov, y0, y1);
      cyc++;
    end
    check("rand_drain", 32'(exp_q.size()), 32'd0);
    check("rand_ovf", 32'(ovf_flag), 32'(any_clip));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
